// File: rtl/issue_ctrl.sv
// Issue-stage controller: buffers fetched instructions in a circular queue, feeds the
// queue head to the decoder and dispatches decoded instructions to the ROB plus RS or LSB.
module issue_ctrl #(
    parameter int IQ_DEPTH  = 8,
    parameter int ROB_TAG_W = 4,
    parameter int OPE_W     = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 if_valid_in,
    input  logic [31:0]          if_ins_in,
    input  logic [31:0]          if_pc_in,
    output logic                 iq_full_out,
    output logic [31:0]          dec_code_out,
    output logic [31:0]          dec_pc_out,
    input  logic [OPE_W-1:0]     dec_type_in,
    input  logic [4:0]           dec_rd_in,
    input  logic [4:0]           dec_rs1_in,
    input  logic [4:0]           dec_rs2_in,
    input  logic [31:0]          dec_imm_in,
    input  logic                 rob_full_in,
    input  logic                 rs_full_in,
    input  logic                 lsb_full_in,
    input  logic [ROB_TAG_W-1:0] rob_tag_in,
    output logic                 issue_rob_out,
    output logic                 issue_rs_out,
    output logic                 issue_lsb_out,
    output logic [OPE_W-1:0]     issue_type_out,
    output logic [31:0]          issue_pc_out,
    output logic [31:0]          issue_imm_out,
    output logic [4:0]           issue_rd_out,
    output logic [4:0]           issue_rs1_out,
    output logic [4:0]           issue_rs2_out,
    output logic [ROB_TAG_W-1:0] issue_tag_out
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(IQ_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    // Decoder type codes LB..SW occupy one contiguous range (LB, LH, LW, LBU, LHU, SB, SH, SW).
    localparam logic [OPE_W-1:0] TYPE_LSB_LO = OPE_W'(6'd11);
    localparam logic [OPE_W-1:0] TYPE_LSB_HI = OPE_W'(6'd18);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e             state_r;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W:0]     count_r;
    logic [31:0]        word_mem_r [IQ_DEPTH];
    logic [31:0]        pc_mem_r   [IQ_DEPTH];

    logic run_s;
    logic enq_s;
    logic iss_s;
    logic is_lsb_s;
    logic is_rob_only_s;
    logic station_ok_s;

    assign iq_full_out  = (count_r == FULL_CNT);
    assign dec_code_out = word_mem_r[head_r];
    assign dec_pc_out   = pc_mem_r[head_r];

    // Classify the decoded head instruction and check that its target station has room.
    always_comb begin
        is_lsb_s      = 1'b0;
        is_rob_only_s = 1'b0;
        station_ok_s  = 1'b0;
        if (dec_type_in == '0) begin
            is_rob_only_s = 1'b1;
        end else if ((dec_type_in >= TYPE_LSB_LO) && (dec_type_in <= TYPE_LSB_HI)) begin
            is_lsb_s = 1'b1;
        end else begin
            is_lsb_s = 1'b0;
        end
        if (is_rob_only_s) begin
            station_ok_s = 1'b1;
        end else if (is_lsb_s) begin
            station_ok_s = !lsb_full_in;
        end else begin
            station_ok_s = !rs_full_in;
        end
    end

    // Enqueue/issue qualifiers; a flush cycle or a frozen pipeline does neither.
    always_comb begin
        run_s = rdy_in && (state_r == ST_RUN) && !flush_in;
        enq_s = 1'b0;
        iss_s = 1'b0;
        if (run_s) begin
            enq_s = if_valid_in && !iq_full_out;
            iss_s = (count_r != '0) && !rob_full_in && station_ok_s;
        end else begin
            enq_s = 1'b0;
            iss_s = 1'b0;
        end
    end

    // Queue storage; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk_in) begin
        if (enq_s && rst_in) begin
            word_mem_r[tail_r] <= if_ins_in;
            pc_mem_r[tail_r]   <= if_pc_in;
        end
    end

    // Control FSM with queue pointers and registered dispatch outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r        <= ST_RUN;
            head_r         <= '0;
            tail_r         <= '0;
            count_r        <= '0;
            issue_rob_out  <= 1'b0;
            issue_rs_out   <= 1'b0;
            issue_lsb_out  <= 1'b0;
            issue_type_out <= '0;
            issue_pc_out   <= 32'd0;
            issue_imm_out  <= 32'd0;
            issue_rd_out   <= 5'd0;
            issue_rs1_out  <= 5'd0;
            issue_rs2_out  <= 5'd0;
            issue_tag_out  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                state_r       <= ST_FLUSH;
                head_r        <= '0;
                tail_r        <= '0;
                count_r       <= '0;
                issue_rob_out <= 1'b0;
                issue_rs_out  <= 1'b0;
                issue_lsb_out <= 1'b0;
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (enq_s) begin
                            tail_r <= tail_r + PTR_ONE;
                        end
                        if (iss_s) begin
                            head_r         <= head_r + PTR_ONE;
                            issue_type_out <= dec_type_in;
                            issue_pc_out   <= dec_pc_out;
                            issue_imm_out  <= dec_imm_in;
                            issue_rd_out   <= dec_rd_in;
                            issue_rs1_out  <= dec_rs1_in;
                            issue_rs2_out  <= dec_rs2_in;
                            issue_tag_out  <= rob_tag_in;
                        end
                        case ({enq_s, iss_s})
                            2'b10:   count_r <= count_r + CNT_ONE;
                            2'b01:   count_r <= count_r - CNT_ONE;
                            default: count_r <= count_r;
                        endcase
                        issue_rob_out <= iss_s;
                        issue_rs_out  <= iss_s && !is_lsb_s && !is_rob_only_s;
                        issue_lsb_out <= iss_s && is_lsb_s;
                    end
                    ST_FLUSH: begin
                        state_r       <= ST_RUN;
                        issue_rob_out <= 1'b0;
                        issue_rs_out  <= 1'b0;
                        issue_lsb_out <= 1'b0;
                    end
                    default: begin
                        state_r       <= ST_RUN;
                        issue_rob_out <= 1'b0;
                        issue_rs_out  <= 1'b0;
                        issue_lsb_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: acts as fetcher, decoder and consumers, and checks
// every dispatch against a scoreboard filled when instructions are offered.
module tb_issue_ctrl;

    localparam int IQ_DEPTH  = 8;
    localparam int ROB_TAG_W = 4;
    localparam int OPE_W     = 6;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 rdy_in;
    logic                 flush_in;
    logic                 if_valid_in;
    logic [31:0]          if_ins_in;
    logic [31:0]          if_pc_in;
    logic                 iq_full_out;
    logic [31:0]          dec_code_out;
    logic [31:0]          dec_pc_out;
    logic [OPE_W-1:0]     dec_type_in;
    logic [4:0]           dec_rd_in;
    logic [4:0]           dec_rs1_in;
    logic [4:0]           dec_rs2_in;
    logic [31:0]          dec_imm_in;
    logic                 rob_full_in;
    logic                 rs_full_in;
    logic                 lsb_full_in;
    logic [ROB_TAG_W-1:0] rob_tag_in;
    logic                 issue_rob_out;
    logic                 issue_rs_out;
    logic                 issue_lsb_out;
    logic [OPE_W-1:0]     issue_type_out;
    logic [31:0]          issue_pc_out;
    logic [31:0]          issue_imm_out;
    logic [4:0]           issue_rd_out;
    logic [4:0]           issue_rs1_out;
    logic [4:0]           issue_rs2_out;
    logic [ROB_TAG_W-1:0] issue_tag_out;

    issue_ctrl #(.IQ_DEPTH(IQ_DEPTH), .ROB_TAG_W(ROB_TAG_W), .OPE_W(OPE_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_valid_in(if_valid_in), .if_ins_in(if_ins_in), .if_pc_in(if_pc_in),
        .iq_full_out(iq_full_out), .dec_code_out(dec_code_out), .dec_pc_out(dec_pc_out),
        .dec_type_in(dec_type_in), .dec_rd_in(dec_rd_in), .dec_rs1_in(dec_rs1_in),
        .dec_rs2_in(dec_rs2_in), .dec_imm_in(dec_imm_in), .rob_full_in(rob_full_in),
        .rs_full_in(rs_full_in), .lsb_full_in(lsb_full_in), .rob_tag_in(rob_tag_in),
        .issue_rob_out(issue_rob_out), .issue_rs_out(issue_rs_out),
        .issue_lsb_out(issue_lsb_out), .issue_type_out(issue_type_out),
        .issue_pc_out(issue_pc_out), .issue_imm_out(issue_imm_out),
        .issue_rd_out(issue_rd_out), .issue_rs1_out(issue_rs1_out),
        .issue_rs2_out(issue_rs2_out), .issue_tag_out(issue_tag_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [5:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        dec_t        d;
        logic [31:0] pc;
        int          cls;   // 0 ROB only, 1 RS, 2 LSB
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    int                checks   = 0;
    int                failures = 0;
    logic              rdy_q;
    logic [ROB_TAG_W-1:0] tag_q;

    // Reference decoder: type codes LUI=1..BGEU=10, LB=11..LHU=15, SB=16..SW=18, ADDI=19, ADD=28.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t r;
        r.rd  = w[11:7];
        r.rs1 = w[19:15];
        r.rs2 = w[24:20];
        r.typ = 6'd0;
        r.imm = 32'd0;
        case (w[6:0])
            7'h13: begin r.typ = 6'd19; r.imm = {{20{w[31]}}, w[31:20]}; end
            7'h03: begin
                r.imm = {{20{w[31]}}, w[31:20]};
                case (w[14:12])
                    3'b000: r.typ = 6'd11;
                    3'b001: r.typ = 6'd12;
                    3'b010: r.typ = 6'd13;
                    3'b100: r.typ = 6'd14;
                    3'b101: r.typ = 6'd15;
                    default: r.typ = 6'd0;
                endcase
            end
            7'h23: begin
                r.imm = {{20{w[31]}}, w[31:25], w[11:7]};
                case (w[14:12])
                    3'b000: r.typ = 6'd16;
                    3'b001: r.typ = 6'd17;
                    3'b010: r.typ = 6'd18;
                    default: r.typ = 6'd0;
                endcase
            end
            7'h33: r.typ = 6'd28;
            default: r.typ = 6'd0;
        endcase
        return r;
    endfunction

    function automatic int cls_of(input logic [5:0] t);
        if (t == 6'd0) return 0;
        if (t >= 6'd11 && t <= 6'd18) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] addw(input logic [4:0] i);
        return {7'd0, i, i + 5'd1, 3'b000, i + 5'd2, 7'h33};
    endfunction

    function automatic logic [31:0] sww(input logic [4:0] i);
        return {7'd0, i, 5'd2, 3'b010, i, 7'h23};
    endfunction

    dec_t dec_s;
    assign dec_s       = decode(dec_code_out);
    assign dec_type_in = dec_s.typ;
    assign dec_rd_in   = dec_s.rd;
    assign dec_rs1_in  = dec_s.rs1;
    assign dec_rs2_in  = dec_s.rs2;
    assign dec_imm_in  = dec_s.imm;

    always @(posedge clk_in) begin
        rdy_q <= rdy_in;
        tag_q <= rob_tag_in;
    end

    // Scoreboard monitor: every fresh dispatch must match the oldest expected entry.
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && rdy_q === 1'b1) begin
            if (issue_rob_out === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_issue: got pc=%h, want no dispatch", issue_pc_out);
                end else begin
                    mon_e = sb.pop_front();
                    if ({issue_rs_out, issue_lsb_out} !== {mon_e.cls == 1, mon_e.cls == 2}) begin
                        failures++;
                        $display("FAIL issue_class pc=%h: got rs/lsb=%b%b, want class %0d",
                                 mon_e.pc, issue_rs_out, issue_lsb_out, mon_e.cls);
                    end
                    checks++;
                    if (issue_type_out !== mon_e.d.typ || issue_pc_out !== mon_e.pc) begin
                        failures++;
                        $display("FAIL issue_type_pc: got type=%0d pc=%h, want type=%0d pc=%h",
                                 issue_type_out, issue_pc_out, mon_e.d.typ, mon_e.pc);
                    end
                    checks++;
                    if ({issue_rd_out, issue_rs1_out, issue_rs2_out, issue_imm_out} !==
                        {mon_e.d.rd, mon_e.d.rs1, mon_e.d.rs2, mon_e.d.imm}) begin
                        failures++;
                        $display("FAIL issue_fields pc=%h: got rd=%0d rs1=%0d rs2=%0d imm=%h, want rd=%0d rs1=%0d rs2=%0d imm=%h",
                                 mon_e.pc, issue_rd_out, issue_rs1_out, issue_rs2_out, issue_imm_out,
                                 mon_e.d.rd, mon_e.d.rs1, mon_e.d.rs2, mon_e.d.imm);
                    end
                    checks++;
                    if (issue_tag_out !== tag_q) begin
                        failures++;
                        $display("FAIL issue_tag pc=%h: got %0d, want %0d", mon_e.pc, issue_tag_out, tag_q);
                    end
                end
            end else begin
                checks++;
                if (issue_rs_out !== 1'b0 || issue_lsb_out !== 1'b0) begin
                    failures++;
                    $display("FAIL stray_strobe: got rob/rs/lsb=%b%b%b, want 000",
                             issue_rob_out, issue_rs_out, issue_lsb_out);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        e.d   = decode(w);
        e.pc  = pc;
        e.cls = cls_of(e.d.typ);
        sb.push_back(e);
    endtask

    task automatic check_count(input string name, input int want);
        checks++;
        if (dut.count_r !== want[3:0]) begin
            failures++;
            $display("FAIL %s: got count=%0d, want %0d", name, dut.count_r, want);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0;
        if_ins_in = 32'd0; if_pc_in = 32'd0; rob_full_in = 1'b0; rs_full_in = 1'b0;
        lsb_full_in = 1'b0; rob_tag_in = 4'd0;
        tick(); tick();
        checks++;
        if ({issue_rob_out, issue_rs_out, issue_lsb_out, iq_full_out} !== 4'b0000 ||
            issue_pc_out !== 32'd0 || issue_tag_out !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs: got strobes/full=%b%b%b%b pc=%h tag=%0d, want 0",
                     issue_rob_out, issue_rs_out, issue_lsb_out, iq_full_out, issue_pc_out, issue_tag_out);
        end
        check_count("reset_count", 0);
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        rob_tag_in = 4'd3;
        if_valid_in = 1'b1; if_ins_in = 32'h00500093; if_pc_in = 32'd0;
        push(32'h00500093, 32'd0);
        tick();
        if_valid_in = 1'b0;
        tick();
        checks++;
        if ({issue_rob_out, issue_rs_out, issue_lsb_out} !== 3'b110 || issue_imm_out !== 32'd5 ||
            issue_rd_out !== 5'd1 || issue_tag_out !== 4'd3) begin
            failures++;
            $display("FAIL addi_latency: got rob/rs/lsb=%b%b%b imm=%0d rd=%0d tag=%0d, want 110 5 1 3",
                     issue_rob_out, issue_rs_out, issue_lsb_out, issue_imm_out, issue_rd_out, issue_tag_out);
        end
        wait_drain("addi");
    endtask

    task automatic test_lsb_stall();
        rob_tag_in = 4'd7;
        lsb_full_in = 1'b1;
        if_valid_in = 1'b1; if_ins_in = 32'h0080A103; if_pc_in = 32'h40;
        push(32'h0080A103, 32'h40);
        tick();
        if_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (issue_rob_out !== 1'b0 || issue_lsb_out !== 1'b0) begin
                failures++;
                $display("FAIL lsb_stall cycle %0d: got rob/lsb=%b%b, want 00", i, issue_rob_out, issue_lsb_out);
            end
        end
        lsb_full_in = 1'b0;
        tick();
        checks++;
        if (issue_lsb_out !== 1'b1 || issue_rs_out !== 1'b0) begin
            failures++;
            $display("FAIL lsb_release: got lsb/rs=%b%b, want 10", issue_lsb_out, issue_rs_out);
        end
        wait_drain("lsb");
    endtask

    task automatic test_back_to_back();
        logic [4:0] i5;
        rob_full_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i5 = 5'(i);
            if_valid_in = 1'b1;
            if_ins_in = i5[0] ? sww(i5) : addw(i5);
            if_pc_in = 32'h1000 + 32'(i * 4);
            push(if_ins_in, if_pc_in);
            rob_tag_in = 4'(i);
            tick();
        end
        check_count("fill_count", 8);
        checks++;
        if (iq_full_out !== 1'b1) begin
            failures++;
            $display("FAIL fill_full: got iq_full=%b, want 1", iq_full_out);
        end
        if_ins_in = addw(5'd8); if_pc_in = 32'h1020;
        tick();
        check_count("ninth_refused", 8);
        rob_full_in = 1'b0;
        tick();
        check_count("full_issue_no_enq", 7);
        push(addw(5'd8), 32'h1020);
        for (int i = 9; i < 14; i++) begin
            tick();
            check_count("steady_count", 7);
            checks++;
            if (issue_rob_out !== 1'b1) begin
                failures++;
                $display("FAIL throughput cycle %0d: got rob=%b, want 1", i, issue_rob_out);
            end
            i5 = 5'(i);
            if_ins_in = i5[0] ? sww(i5) : addw(i5);
            if_pc_in = 32'h1000 + 32'(i * 4);
            rob_tag_in = 4'(i);
            if (i < 13) push(if_ins_in, if_pc_in);
            else if_valid_in = 1'b0;
        end
        wait_drain("fill");
        check_count("fill_empty", 0);
    endtask

    task automatic test_flush();
        rob_full_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_valid_in = 1'b1; if_ins_in = addw(5'(i)); if_pc_in = 32'h300 + 32'(i * 4);
            tick();
        end
        check_count("pre_flush", 5);
        flush_in = 1'b1; rob_full_in = 1'b0;
        if_ins_in = addw(5'd20); if_pc_in = 32'h200;
        tick();
        flush_in = 1'b0;
        check_count("flush_clear", 0);
        checks++;
        if ({issue_rob_out, issue_rs_out, issue_lsb_out} !== 3'b000) begin
            failures++;
            $display("FAIL flush_strobes: got %b%b%b, want 000", issue_rob_out, issue_rs_out, issue_lsb_out);
        end
        tick();
        check_count("flush_refuse", 0);
        push(addw(5'd20), 32'h200);
        tick();
        check_count("flush_accept", 1);
        if_valid_in = 1'b0;
        tick();
        checks++;
        if (issue_rob_out !== 1'b1) begin
            failures++;
            $display("FAIL flush_issue: got rob=%b, want 1", issue_rob_out);
        end
        wait_drain("flush");
    endtask

    task automatic test_illegal();
        rs_full_in = 1'b1; lsb_full_in = 1'b1; rob_tag_in = 4'd12;
        if_valid_in = 1'b1; if_ins_in = 32'h00000000; if_pc_in = 32'h500;
        push(32'h00000000, 32'h500);
        tick();
        if_valid_in = 1'b0;
        tick();
        checks++;
        if ({issue_rob_out, issue_rs_out, issue_lsb_out} !== 3'b100 || issue_type_out !== 6'd0) begin
            failures++;
            $display("FAIL illegal: got rob/rs/lsb=%b%b%b type=%0d, want 100 type 0",
                     issue_rob_out, issue_rs_out, issue_lsb_out, issue_type_out);
        end
        wait_drain("illegal");
        rs_full_in = 1'b0; lsb_full_in = 1'b0;
    endtask

    task automatic test_freeze_reset();
        dec_t fd;
        rob_full_in = 1'b1; rob_tag_in = 4'd9;
        for (int i = 0; i < 4; i++) begin
            if_valid_in = 1'b1; if_ins_in = addw(5'(i + 4)); if_pc_in = 32'h600 + 32'(i * 4);
            push(if_ins_in, if_pc_in);
            tick();
        end
        if_valid_in = 1'b0;
        rob_full_in = 1'b0;
        tick();
        fd = decode(addw(5'd4));
        rdy_in = 1'b0; flush_in = 1'b1; if_valid_in = 1'b1; if_ins_in = addw(5'd30);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_count("freeze_count", 3);
            checks++;
            if ({issue_rob_out, issue_rs_out, issue_lsb_out} !== 3'b110 || issue_pc_out !== 32'h600 ||
                issue_rd_out !== fd.rd || issue_tag_out !== 4'd9) begin
                failures++;
                $display("FAIL freeze_hold %0d: got %b%b%b pc=%h rd=%0d tag=%0d, want 110 pc=600 rd=%0d tag=9",
                         i, issue_rob_out, issue_rs_out, issue_lsb_out, issue_pc_out, issue_rd_out,
                         issue_tag_out, fd.rd);
            end
        end
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({issue_rob_out, issue_rs_out, issue_lsb_out, iq_full_out} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset: got rob/rs/lsb/full=%b%b%b%b, want 0000",
                     issue_rob_out, issue_rs_out, issue_lsb_out, iq_full_out);
        end
        check_count("async_reset_count", 0);
        sb.delete();
        rdy_in = 1'b1; flush_in = 1'b0; if_valid_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        rob_tag_in = 4'd1;
        if_valid_in = 1'b1; if_ins_in = 32'h0080A103; if_pc_in = 32'h700;
        push(32'h0080A103, 32'h700);
        tick();
        if_valid_in = 1'b0;
        wait_drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lsb_stall();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_freeze_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
